adder_rr_arbiter: RTL

Round-robin arbiter that shares one `adder` instance between `NREQ` requesters. Each requester offers an operand pair on its own valid/ready channel. The arbiter forwards one granted pair per cycle to the adder's A/B channels and records the requester index in an in-order tag FIFO. It then routes each adder result on S back to the requester that issued it. The block sits between the requester blocks and the shared adder and contains all sequencing state for that adder.

---
 rtl/adder_rr_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_arbiter
// Description : Round-robin arbiter that shares one registered adder among
//               NREQ requesters. Granted operand pairs go to the adder A/B
//               channels. The requester index of each issue is queued in an
//               in-order tag FIFO, and each result on S is routed back to the
//               requester at the head of that FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int TAGDEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    // Requester side
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*WIDTH-1:0]         req_a,
    input  logic [NREQ*WIDTH-1:0]         req_b,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [WIDTH:0]                rsp_data,

    // Shared adder side
    output logic                          A_valid,
    input  logic                          A_ready,
    output logic [WIDTH-1:0]              A_data,
    output logic                          B_valid,
    input  logic                          B_ready,
    output logic [WIDTH-1:0]              B_data,
    input  logic                          S_valid,
    output logic                          S_ready,
    input  logic [WIDTH:0]                S_data,

    // Status
    output logic [$clog2(TAGDEPTH):0]     outstanding,
    output logic                          err_orphan
);

    localparam int c_PTR_W  = $clog2(NREQ);
    localparam int c_TAG_AW = $clog2(TAGDEPTH);
    localparam int c_CNT_W  = c_TAG_AW + 1;

    localparam logic [c_PTR_W-1:0] c_LAST_REQ  = c_PTR_W'(NREQ - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(TAGDEPTH);
    localparam logic [c_PTR_W:0]   c_NREQ_EXT  = (c_PTR_W + 1)'(NREQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  r_tag_mem [TAGDEPTH];
    logic [c_TAG_AW-1:0] r_wr_ptr;
    logic [c_TAG_AW-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_err_orphan;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    w_a_arr [NREQ];
    logic [WIDTH-1:0]    w_b_arr [NREQ];
    logic [c_PTR_W-1:0]  w_grant;
    logic                w_found;
    logic [NREQ-1:0]     w_grant_oh;
    logic                w_any_req;
    logic                w_empty;
    logic                w_full;
    logic                w_valid_out;
    logic                w_issue;
    logic                w_pop;
    logic [c_PTR_W-1:0]  w_head_tag;
    logic [NREQ-1:0]     w_head_oh;

    // Slice the flat operand buses into per-requester words.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign w_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotating priority search: first valid requester at or after r_ptr,
    // wrapping from NREQ-1 back to 0.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [c_PTR_W:0] w_idx;
            w_idx = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (w_idx >= c_NREQ_EXT) begin
                w_idx = w_idx - c_NREQ_EXT;
            end
            if (!w_found && req_valid[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_any_req  = |req_valid;
    assign w_grant_oh = NREQ'(1) << w_grant;

    // FIFO status. A full FIFO blocks issue even when a pop happens in the
    // same cycle; this keeps valid free of any ready-to-valid path.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);

    // Adder drive: valid depends only on requests and FIFO state, never on
    // the adder's ready, which itself depends on valid.
    assign w_valid_out = w_any_req && !w_full;
    assign A_valid     = w_valid_out;
    assign B_valid     = w_valid_out;
    assign A_data      = w_a_arr[w_grant];
    assign B_data      = w_b_arr[w_grant];

    assign w_issue   = w_valid_out && A_ready && B_ready;
    assign req_ready = w_issue ? w_grant_oh : '0;

    // Return path: the head tag selects which requester sees the result.
    assign w_head_tag = r_tag_mem[r_rd_ptr];
    assign w_head_oh  = NREQ'(1) << w_head_tag;

    assign rsp_valid = (!w_empty && S_valid) ? w_head_oh : '0;
    assign rsp_data  = S_data;
    assign S_ready   = !w_empty && rsp_ready[w_head_tag];
    assign w_pop     = S_valid && S_ready;

    assign outstanding = r_count;
    assign err_orphan  = r_err_orphan;

    // Round-robin pointer advances past the requester just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_grant == c_LAST_REQ) ? '0 : (w_grant + c_PTR_W'(1));
        end
    end

    // Tag storage: write the granted index at the tail on each issue.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_mem[r_wr_ptr] <= w_grant;
        end
    end

    // Tag FIFO pointers and occupancy; address pointers wrap naturally since
    // the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + c_TAG_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_TAG_AW'(1);
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a result that no issued tag can account for.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_orphan <= 1'b0;
        end else if (S_valid && w_empty) begin
            r_err_orphan <= 1'b1;
        end
    end

endmodule
`default_nettype wire
